// File: rtl/femto_ctrl_pkg.sv
// Shared types and encodings for the FemtoRV32 multi-cycle sequencer.
// Holds the FSM state enum, opcode constants (IR[6:2]), the opcode-class
// enum latched in DECODE, the pc_src / wb_sel / aluop encodings and a
// helper that maps a raw opcode onto its class.
package femto_ctrl_pkg;

  typedef enum logic [2:0] {
    ST_IDLE, ST_FETCH, ST_DECODE, ST_EXECUTE, ST_MEM, ST_WB, ST_TRAP
  } state_e;

  typedef enum logic [3:0] {
    CLS_R, CLS_I, CLS_LD, CLS_ST, CLS_BR, CLS_JAL, CLS_JALR,
    CLS_AUIPC, CLS_LUI, CLS_ILL
  } opcls_e;

  localparam logic [4:0] OP_R     = 5'b01100;
  localparam logic [4:0] OP_LD    = 5'b00000;
  localparam logic [4:0] OP_ST    = 5'b01000;
  localparam logic [4:0] OP_BR    = 5'b11000;
  localparam logic [4:0] OP_I     = 5'b00100;
  localparam logic [4:0] OP_JAL   = 5'b11011;
  localparam logic [4:0] OP_JALR  = 5'b11001;
  localparam logic [4:0] OP_AUIPC = 5'b00101;
  localparam logic [4:0] OP_LUI   = 5'b01101;

  localparam logic [1:0] PC_PLUS4 = 2'b00;
  localparam logic [1:0] PC_IMM   = 2'b01;
  localparam logic [1:0] PC_ALU   = 2'b10;

  localparam logic [1:0] WB_ALU   = 2'b00;
  localparam logic [1:0] WB_MEM   = 2'b01;
  localparam logic [1:0] WB_PC4   = 2'b10;
  localparam logic [1:0] WB_IMM   = 2'b11;

  localparam logic [1:0] ALU_ADD   = 2'b00;
  localparam logic [1:0] ALU_CMP   = 2'b01;
  localparam logic [1:0] ALU_FUNCT = 2'b10;
  localparam logic [1:0] ALU_PASS  = 2'b11;

  function automatic opcls_e op_class(input logic [4:0] op);
    opcls_e c;
    case (op)
      OP_R:     c = CLS_R;
      OP_LD:    c = CLS_LD;
      OP_ST:    c = CLS_ST;
      OP_BR:    c = CLS_BR;
      OP_I:     c = CLS_I;
      OP_JAL:   c = CLS_JAL;
      OP_JALR:  c = CLS_JALR;
      OP_AUIPC: c = CLS_AUIPC;
      OP_LUI:   c = CLS_LUI;
      default:  c = CLS_ILL;
    endcase
    return c;
  endfunction

endpackage

// File: rtl/mc_timeout_ctr.sv
// Wait-cycle counter for memory requests.
// Ports:
//   clk, rst_n  clock / async active-low reset
//   clr_i       hold count at zero (outside a memory request)
//   en_i        count one waited cycle (request pending, not ready)
//   expired_o   count has reached TIMEOUT-1: last cycle the request may
//               still be accepted
module mc_timeout_ctr #(
  parameter int TO_W    = 5,
  parameter int TIMEOUT = 16
) (
  input  logic clk,
  input  logic rst_n,
  input  logic clr_i,
  input  logic en_i,
  output logic expired_o
);

  localparam logic [TO_W-1:0] LIMIT = TO_W'(TIMEOUT - 1);

  logic [TO_W-1:0] cnt_q, cnt_d;

  always_comb begin
    cnt_d = cnt_q;
    if (clr_i)                       cnt_d = '0;
    else if (en_i && cnt_q != LIMIT) cnt_d = cnt_q + TO_W'(1);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) cnt_q <= '0;
    else        cnt_q <= cnt_d;
  end

  assign expired_o = (cnt_q == LIMIT);

endmodule

// File: rtl/multicycle_seq_ctrl.sv
// Multi-cycle sequencer for the FemtoRV32 datapath. One memory port is
// shared between instruction fetch (FETCH) and load/store data (MEM).
// Strobes are decoded from the registered state and the opcode class
// latched in DECODE; the handshake strobes (ir_we, store pc_we/instret)
// also look at mem_ready in the accepting cycle.
// Ports:
//   clk, rst_n      clock / async active-low reset
//   halt            park in IDLE (sampled only there)
//   opcode          IR[6:2], valid from DECODE onward
//   branch_taken    ALU compare result, used in EXECUTE
//   mem_ready       memory completes the current request
//   mem_req/mem_we/mem_addr_sel  memory request, store flag, 0=PC 1=ALU
//   ir_we, pc_we, pc_src         IR latch, PC update and PC source
//   alusrc, aluop                ALU operand / operation select
//   regwrite, wb_sel             regfile write strobe and source
//   instret                      one pulse per retired instruction
//   trap, illegal_insn, bus_err  sticky trap flag and causes
module multicycle_seq_ctrl
  import femto_ctrl_pkg::*;
#(
  parameter int TIMEOUT = 16,
  parameter int TO_W    = 5
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       halt,
  input  logic [4:0] opcode,
  input  logic       branch_taken,
  input  logic       mem_ready,
  output logic       mem_req,
  output logic       mem_we,
  output logic       mem_addr_sel,
  output logic       ir_we,
  output logic       pc_we,
  output logic [1:0] pc_src,
  output logic       alusrc,
  output logic [1:0] aluop,
  output logic       regwrite,
  output logic [1:0] wb_sel,
  output logic       instret,
  output logic       trap,
  output logic       illegal_insn,
  output logic       bus_err
);

  state_e state_q, state_d;
  opcls_e cls_q, cls_d;
  logic   trap_q, trap_d;
  logic   ill_q, ill_d;
  logic   berr_q, berr_d;
  logic   to_expired;

  // Counter is held clear outside FETCH/MEM, so each request starts at 0.
  mc_timeout_ctr #(.TO_W(TO_W), .TIMEOUT(TIMEOUT)) u_to (
    .clk      (clk),
    .rst_n    (rst_n),
    .clr_i    (!(state_q == ST_FETCH || state_q == ST_MEM)),
    .en_i     (mem_req && !mem_ready),
    .expired_o(to_expired)
  );

  always_comb begin
    state_d      = state_q;
    cls_d        = cls_q;
    ill_d        = ill_q;
    berr_d       = berr_q;
    mem_req      = 1'b0;
    mem_we       = 1'b0;
    mem_addr_sel = 1'b0;
    ir_we        = 1'b0;
    pc_we        = 1'b0;
    pc_src       = PC_PLUS4;
    alusrc       = 1'b0;
    aluop        = ALU_ADD;
    regwrite     = 1'b0;
    wb_sel       = WB_ALU;
    instret      = 1'b0;

    unique case (state_q)
      ST_IDLE: if (!halt) state_d = ST_FETCH;

      ST_FETCH: begin
        mem_req = 1'b1;
        // Ready on the limit cycle still wins over the timeout.
        if (mem_ready) begin
          ir_we   = 1'b1;
          state_d = ST_DECODE;
        end else if (to_expired) begin
          berr_d  = 1'b1;
          state_d = ST_TRAP;
        end
      end

      ST_DECODE: begin
        cls_d = op_class(opcode);
        if (cls_d == CLS_ILL) begin
          ill_d   = 1'b1;
          state_d = ST_TRAP;
        end else begin
          state_d = ST_EXECUTE;
        end
      end

      ST_EXECUTE: begin
        unique case (cls_q)
          CLS_R:                      begin alusrc = 1'b0; aluop = ALU_FUNCT; end
          CLS_I, CLS_LUI:             begin alusrc = 1'b1; aluop = ALU_FUNCT; end
          CLS_LD, CLS_ST, CLS_AUIPC:  begin alusrc = 1'b1; aluop = ALU_ADD;   end
          CLS_BR:                     begin alusrc = 1'b0; aluop = ALU_CMP;   end
          CLS_JAL, CLS_JALR:          begin alusrc = 1'b1; aluop = ALU_PASS;  end
          default: ;
        endcase
        if (cls_q == CLS_LD || cls_q == CLS_ST) begin
          state_d = ST_MEM;
        end else if (cls_q == CLS_BR) begin
          pc_we   = 1'b1;
          pc_src  = branch_taken ? PC_IMM : PC_PLUS4;
          instret = 1'b1;
          state_d = ST_IDLE;
        end else begin
          state_d = ST_WB;
        end
      end

      ST_MEM: begin
        mem_req      = 1'b1;
        mem_addr_sel = 1'b1;
        mem_we       = (cls_q == CLS_ST);
        if (mem_ready) begin
          if (cls_q == CLS_ST) begin
            pc_we   = 1'b1;
            instret = 1'b1;
            state_d = ST_IDLE;
          end else begin
            state_d = ST_WB;
          end
        end else if (to_expired) begin
          berr_d  = 1'b1;
          state_d = ST_TRAP;
        end
      end

      ST_WB: begin
        regwrite = 1'b1;
        pc_we    = 1'b1;
        instret  = 1'b1;
        unique case (cls_q)
          CLS_LD:            wb_sel = WB_MEM;
          CLS_JAL, CLS_JALR: wb_sel = WB_PC4;
          CLS_LUI:           wb_sel = WB_IMM;
          default:           wb_sel = WB_ALU;
        endcase
        unique case (cls_q)
          CLS_JAL:  pc_src = PC_IMM;
          CLS_JALR: pc_src = PC_ALU;
          default:  pc_src = PC_PLUS4;
        endcase
        state_d = ST_IDLE;
      end

      ST_TRAP: ;  // only rst_n leaves

      default: state_d = ST_IDLE;
    endcase

    trap_d = ill_d | berr_d;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= ST_IDLE;
      cls_q   <= CLS_ILL;
      trap_q  <= 1'b0;
      ill_q   <= 1'b0;
      berr_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      cls_q   <= cls_d;
      trap_q  <= trap_d;
      ill_q   <= ill_d;
      berr_q  <= berr_d;
    end
  end

  assign trap         = trap_q;
  assign illegal_insn = ill_q;
  assign bus_err      = berr_q;

endmodule

// File: tb/tb_multicycle_seq_ctrl.sv
// Bench for multicycle_seq_ctrl. A driver answers memory requests after a
// programmed number of wait cycles; the stimulus pushes one expected
// retirement/trap record per instruction; a monitor profiles every
// instruction from its first fetch cycle and compares at instret or at the
// first trap cycle.
module tb_multicycle_seq_ctrl;

  logic       clk = 1'b0, rst_n = 1'b0, halt = 1'b1;
  logic       branch_taken = 1'b0, mem_ready = 1'b0;
  logic [4:0] opcode = 5'b0;
  logic       mem_req, mem_we, mem_addr_sel, ir_we, pc_we, alusrc;
  logic       regwrite, instret, trap, illegal_insn, bus_err;
  logic [1:0] pc_src, aluop, wb_sel;
  logic [16:0] outs;

  assign outs = {mem_req, mem_we, mem_addr_sel, ir_we, pc_we, pc_src, alusrc,
                 aluop, regwrite, wb_sel, instret, trap, illegal_insn, bus_err};

  multicycle_seq_ctrl #(.TIMEOUT(16), .TO_W(5)) dut (
    .clk(clk), .rst_n(rst_n), .halt(halt), .opcode(opcode),
    .branch_taken(branch_taken), .mem_ready(mem_ready), .mem_req(mem_req),
    .mem_we(mem_we), .mem_addr_sel(mem_addr_sel), .ir_we(ir_we), .pc_we(pc_we),
    .pc_src(pc_src), .alusrc(alusrc), .aluop(aluop), .regwrite(regwrite),
    .wb_sel(wb_sel), .instret(instret), .trap(trap),
    .illegal_insn(illegal_insn), .bus_err(bus_err)
  );

  initial forever #5 clk = ~clk;

  typedef struct {
    bit       trap, ill, berr;
    int       lat;    // cycles from first FETCH cycle to event cycle
    bit       asrc;
    bit [1:0] aop;    // ALU controls two cycles after ir_we (EXECUTE)
    int       rwc;    // regwrite cycles
    bit [1:0] wb, pcs;
    bit       pcwe;
    int       irc;    // ir_we cycles
    int       dcyc;   // data-phase mem_req cycles
    bit       dwe;
  } exp_t;

  exp_t sb[$];
  exp_t e;
  int n_chk = 0, n_fail = 0;

  function automatic void chk(input string nm, input int got, input int want);
    n_chk++;
    if (got != want) begin
      n_fail++;
      $display("FAIL %s: got %0d want %0d (t=%0t)", nm, got, want, $time);
    end
  endfunction

  function automatic exp_t mk(bit t, bit il, bit be, int lat, bit as, bit [1:0] ao,
                              int rwc, bit [1:0] wb, bit [1:0] pcs, bit pcwe,
                              int irc, int dc, bit dwe);
    exp_t r;
    r.trap = t; r.ill = il; r.berr = be; r.lat = lat; r.asrc = as; r.aop = ao;
    r.rwc = rwc; r.wb = wb; r.pcs = pcs; r.pcwe = pcwe; r.irc = irc;
    r.dcyc = dc; r.dwe = dwe;
    return r;
  endfunction

  // Memory responder: ready after fwait/dwait wait cycles; optional spurious
  // ready whenever no request is pending.
  int fwait = 0, dwait = 0, wcnt = 0;
  bit spur = 1'b0;
  initial forever begin
    @(negedge clk);
    if (mem_req) begin
      mem_ready = (wcnt == (mem_addr_sel ? dwait : fwait));
      wcnt++;
    end else begin
      mem_ready = spur;
      wcnt = 0;
    end
  end

  // Monitor
  bit m_act = 0, m_tseen = 0, m_dwe = 0, m_asrc = 0;
  bit [1:0] m_aop = 0;
  int m_lat = 0, m_rw = 0, m_ir = 0, m_dc = 0, m_since = -1;
  initial forever begin
    @(negedge clk); #1;
    if (!rst_n) begin
      m_act = 0; m_tseen = 0;
    end else begin
      if (!m_act && mem_req && !mem_addr_sel) begin
        m_act = 1; m_lat = 0; m_rw = 0; m_ir = 0; m_dc = 0; m_since = -1;
        m_dwe = 0; m_asrc = 0; m_aop = 0;
      end
      if (m_act) begin
        m_lat++;
        if (m_since >= 0) m_since++;
        if (m_since == 2) begin m_asrc = alusrc; m_aop = aluop; end
        if (ir_we) begin m_ir++; m_since = 0; end
        if (regwrite) m_rw++;
        if (mem_req && mem_addr_sel) begin
          if (m_dc == 0) m_dwe = mem_we;
          m_dc++;
        end
        if (instret || (trap && !m_tseen)) begin
          if (trap) m_tseen = 1;
          m_act = 0;
          if (sb.size() == 0) begin
            n_chk++; n_fail++;
            $display("FAIL unexpected_event: got instret=%0d trap=%0d want none", instret, trap);
          end else begin
            e = sb.pop_front();
            chk("no_x", int'($isunknown(outs)), 0);
            chk("trap", trap, e.trap);
            chk("illegal_insn", illegal_insn, e.ill);
            chk("bus_err", bus_err, e.berr);
            chk("latency", m_lat, e.lat);
            chk("alusrc", m_asrc, e.asrc);
            chk("aluop", m_aop, e.aop);
            chk("regwrite_cycles", m_rw, e.rwc);
            chk("wb_sel", wb_sel, e.wb);
            chk("pc_src", pc_src, e.pcs);
            chk("pc_we", pc_we, e.pcwe);
            chk("ir_we_cycles", m_ir, e.irc);
            chk("data_req_cycles", m_dc, e.dcyc);
            chk("mem_we", m_dwe, e.dwe);
          end
        end
      end else if (instret || regwrite || ir_we) begin
        n_chk++; n_fail++;
        $display("FAIL stray_strobe: got instret=%0d regwrite=%0d ir_we=%0d want 0", instret, regwrite, ir_we);
      end
    end
  end

  task automatic wait_empty(input int budget);
    for (int i = 0; i < budget && sb.size() != 0; i++) @(negedge clk);
    if (sb.size() != 0) begin
      n_chk++; n_fail++;
      $display("FAIL event_timeout: got %0d pending want 0", sb.size());
      sb.delete();
    end
  endtask

  task automatic run(input logic [4:0] op, input logic bt, input int fw, input int dw,
                     input bit sp, input exp_t x);
    sb.push_back(x);
    opcode = op; branch_taken = bt; fwait = fw; dwait = dw; spur = sp;
    @(negedge clk); halt = 1'b0;
    @(negedge clk); halt = 1'b1;
    wait_empty(200);
    repeat (2) @(negedge clk);
  endtask

  task automatic do_reset();
    @(negedge clk); rst_n = 1'b0; #2;
    chk("reset_outputs", int'(outs), 0);
    @(negedge clk); rst_n = 1'b1; fwait = 0; dwait = 0; spur = 0;
    @(negedge clk);
  endtask

  initial begin
    #2;
    chk("reset_outputs", int'(outs), 0);
    @(negedge clk); rst_n = 1'b1;
    repeat (2) @(negedge clk);
    chk("idle_halted_no_req", mem_req, 0);

    //        op        bt fw dw sp      trap il be lat as aop   rw wb     pcs   pw ir dc we
    run(5'b01100, 0, 0, 0, 0, mk(0, 0, 0, 4,  0, 2'b10, 1, 2'b00, 2'b00, 1, 1, 0, 0)); // R 0x00B50533
    run(5'b00000, 0, 0, 3, 0, mk(0, 0, 0, 8,  1, 2'b00, 1, 2'b01, 2'b00, 1, 1, 4, 0)); // LW, 3 waits
    run(5'b11000, 1, 0, 0, 0, mk(0, 0, 0, 3,  0, 2'b01, 0, 2'b00, 2'b01, 1, 1, 0, 0)); // BEQ taken
    run(5'b11000, 0, 0, 0, 0, mk(0, 0, 0, 3,  0, 2'b01, 0, 2'b00, 2'b00, 1, 1, 0, 0)); // BEQ not taken
    run(5'b00100, 0, 2, 0, 1, mk(0, 0, 0, 6,  1, 2'b10, 1, 2'b00, 2'b00, 1, 1, 0, 0)); // ADDI, spurious ready
    run(5'b11011, 0, 0, 0, 0, mk(0, 0, 0, 4,  1, 2'b11, 1, 2'b10, 2'b01, 1, 1, 0, 0)); // JAL
    run(5'b11001, 0, 0, 0, 0, mk(0, 0, 0, 4,  1, 2'b11, 1, 2'b10, 2'b10, 1, 1, 0, 0)); // JALR
    run(5'b00101, 0, 0, 0, 0, mk(0, 0, 0, 4,  1, 2'b00, 1, 2'b00, 2'b00, 1, 1, 0, 0)); // AUIPC
    run(5'b01101, 0, 0, 0, 0, mk(0, 0, 0, 4,  1, 2'b10, 1, 2'b11, 2'b00, 1, 1, 0, 0)); // LUI
    run(5'b01000, 0, 0, 0, 0, mk(0, 0, 0, 4,  1, 2'b00, 0, 2'b00, 2'b00, 1, 1, 1, 1)); // SW
    run(5'b01100, 0, 15, 0, 0, mk(0, 0, 0, 19, 0, 2'b10, 1, 2'b00, 2'b00, 1, 1, 0, 0)); // ready on limit cycle
    // SW with halt raised right after fetch: completes, then parks.
    run(5'b01000, 0, 0, 2, 0, mk(0, 0, 0, 6,  1, 2'b00, 0, 2'b00, 2'b00, 1, 1, 3, 1));
    for (int i = 0; i < 5; i++) begin
      @(negedge clk); #1;
      chk("halt_parked_no_req", mem_req, 0);
    end

    // Illegal opcode: sticky trap, halt cannot restart it.
    run(5'b11111, 0, 0, 0, 0, mk(1, 1, 0, 3, 0, 2'b00, 0, 2'b00, 2'b00, 0, 1, 0, 0));
    halt = 1'b0;
    for (int i = 0; i < 20; i++) begin
      @(negedge clk); #1;
      chk("trap_held", {trap, illegal_insn, bus_err, mem_req}, 4'b1100);
    end
    halt = 1'b1;
    do_reset();

    // Fetch never answered: bus_err after 16 waiting cycles.
    run(5'b01100, 0, 1000, 0, 0, mk(1, 0, 1, 17, 0, 2'b00, 0, 2'b00, 2'b00, 0, 0, 0, 0));
    do_reset();
    // Load data phase never answered.
    run(5'b00000, 0, 0, 1000, 0, mk(1, 0, 1, 20, 1, 2'b00, 0, 2'b00, 2'b00, 0, 1, 16, 0));
    do_reset();

    // Reset in the middle of a store's data phase: nothing retires.
    opcode = 5'b01000; fwait = 0; dwait = 1000;
    @(negedge clk); halt = 1'b0;
    @(negedge clk); halt = 1'b1;
    for (int i = 0; i < 50 && !(mem_req && mem_addr_sel); i++) @(negedge clk);
    chk("mid_mem_reached", int'(mem_req && mem_addr_sel), 1);
    repeat (2) @(negedge clk);
    rst_n = 1'b0; #2;
    chk("abort_mem_req", mem_req, 0);
    chk("abort_outputs", int'(outs), 0);
    @(negedge clk); rst_n = 1'b1; dwait = 0;
    repeat (10) @(negedge clk);
    chk("abort_no_retire", sb.size(), 0);
    chk("after_abort_idle", mem_req, 0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL global_timeout: got running want finished");
    $fatal(1, "global timeout");
  end

endmodule
